// File: rtl/ft_pkg.sv
// Shared types and defaults for the lockstep recovery sequencer.
package ft_pkg;

  localparam int FT_ADDR_WIDTH = 5;
  localparam int FT_DATA_WIDTH = 32;
  localparam int RETRY_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_HALT    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_SETPC   = 3'd4,
    ST_RESUME  = 3'd5
  } ft_rec_state_t;

  // Retry counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ft_recovery_ctrl_restore_seq.sv
// ft_restore_seq: walks the checkpoint file once and replays it into the
// register copies. The read address steps one per cycle; the write port is
// delayed by one cycle to line up with the checkpoint's synchronous read.
//
// Handshake: start_i is a single-cycle request, honoured in any cycle.
// done_o is high during the cycle that carries the write of the last address;
// the owner moves on at the following edge.
module ft_restore_seq
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic                  rd_act_q, rd_act_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;

  // Read-address walk and one-cycle write-alignment stage.
  always_comb begin
    rd_act_d = rd_act_q;
    raddr_d  = raddr_q;
    we_d     = rd_act_q;
    waddr_d  = raddr_q;
    if (start_i) begin
      rd_act_d = 1'b1;
      raddr_d  = '0;
    end else if (rd_act_q) begin
      // The address parks on the last entry rather than wrapping to 0.
      if (raddr_q == LAST_ADDR) rd_act_d = 1'b0;
      else                      raddr_d  = raddr_q + 1'b1;
    end
  end

  // Sequencer registers, cleared asynchronously so a reset aborts the replay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_act_q <= 1'b0;
      raddr_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
    end else begin
      rd_act_q <= rd_act_d;
      raddr_q  <= raddr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
    end
  end

  assign raddr_o = raddr_q;
  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  // Read data already leaves the checkpoint file on a register; it is forwarded
  // in the cycle it arrives (gated by the registered enable) so each write
  // lands exactly one cycle after its read address.
  assign wdata_o = we_q ? rdata_i : '0;
  assign done_o  = we_q && (waddr_q == LAST_ADDR);

endmodule

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: recovery sequencer for the lockstep register file.
// On an accepted mismatch: halt cores, replay the checkpoint file, reload the
// saved PC, pulse resume. Retries are counted inside a clean window.
// Build option FT_SHIFT_EN: when defined, reaching MAX_RETRY routes the next
// recovery through a one-cycle spare-core shift; when undefined, recovery
// retries indefinitely and shift_o stays 0.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = FT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FT_DATA_WIDTH,
  parameter int HALT_CYCLES  = 2,
  parameter int MAX_RETRY    = 3,
  parameter int CLEAN_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] spc_i,
  input  logic [DATA_WIDTH-1:0] ck_rdata_i,
  output logic [ADDR_WIDTH-1:0] ck_raddr_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  pc_we_o,
  output logic                  halt_o,
  output logic                  resume_o,
  output logic                  shift_o,
  output logic                  busy_o,
  output logic [RETRY_W-1:0]    retry_cnt_o
);

  localparam int HALT_W  = 4;
  localparam int CLEAN_W = $clog2(CLEAN_CYCLES + 1);
  localparam logic [HALT_W-1:0]  HALT_LAST  = HALT_W'(HALT_CYCLES - 1);
  localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  ft_rec_state_t         state_q, state_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [CLEAN_W-1:0]    clean_q, clean_d;
  logic [HALT_W-1:0]     halt_cnt_q, halt_cnt_d;
  logic [DATA_WIDTH-1:0] pc_cap_q, pc_cap_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_we_q, pc_we_d;
  logic                  halt_q, halt_d;
  logic                  resume_q, resume_d;
  logic                  shift_q, shift_d;
  logic                  busy_q, busy_d;

  logic restore_start;
  logic restore_done;
  logic retry_at_max;
  logic shift_take;

  assign retry_at_max = (retry_q == RETRY_MAX);
`ifdef FT_SHIFT_EN
  assign shift_take = retry_at_max;
`else
  // Shift path disabled: the limit comparison is tied off, so recovery
  // always goes straight to HALT.
  assign shift_take = retry_at_max & 1'b0;
`endif

  // Next-state, retry/clean bookkeeping and PC capture.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    clean_d       = clean_q;
    halt_cnt_d    = halt_cnt_q;
    pc_cap_d      = pc_cap_q;
    restore_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (err_i) begin
          pc_cap_d   = spc_i;
          clean_d    = '0;
          halt_cnt_d = '0;
          if (shift_take) begin
            state_d = ST_SHIFT;
            retry_d = '0;
          end else begin
            state_d = ST_HALT;
            retry_d = retry_sat_inc(retry_q);
          end
        end else if (clean_q == CLEAN_LAST) begin
          clean_d = '0;
          retry_d = '0;
        end else begin
          clean_d = clean_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // The recovery run on the fresh core is the first retry of its window.
        state_d = ST_HALT;
        retry_d = retry_sat_inc(retry_q);
      end
      ST_HALT: begin
        if (halt_cnt_q == HALT_LAST) begin
          state_d       = ST_RESTORE;
          restore_start = 1'b1;
        end else begin
          halt_cnt_d = halt_cnt_q + 1'b1;
        end
      end
      ST_RESTORE: begin
        if (restore_done) state_d = ST_SETPC;
      end
      ST_SETPC:  state_d = ST_RESUME;
      ST_RESUME: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    halt_d   = (state_d == ST_SHIFT) || (state_d == ST_HALT) ||
               (state_d == ST_RESTORE) || (state_d == ST_SETPC);
    busy_d   = (state_d != ST_IDLE);
    resume_d = (state_d == ST_RESUME);
    pc_we_d  = (state_d == ST_SETPC);
    pc_d     = (state_d == ST_SETPC) ? pc_cap_q : pc_q;
`ifdef FT_SHIFT_EN
    shift_d  = (state_d == ST_SHIFT);
`else
    shift_d  = 1'b0;
`endif
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      clean_q    <= '0;
      halt_cnt_q <= '0;
      pc_cap_q   <= '0;
      pc_q       <= '0;
      pc_we_q    <= 1'b0;
      halt_q     <= 1'b0;
      resume_q   <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      clean_q    <= clean_d;
      halt_cnt_q <= halt_cnt_d;
      pc_cap_q   <= pc_cap_d;
      pc_q       <= pc_d;
      pc_we_q    <= pc_we_d;
      halt_q     <= halt_d;
      resume_q   <= resume_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
    end
  end

  ft_restore_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_restore_seq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (restore_start),
    .rdata_i (ck_rdata_i),
    .raddr_o (ck_raddr_o),
    .we_o    (rf_we_o),
    .waddr_o (rf_waddr_o),
    .wdata_o (rf_wdata_o),
    .done_o  (restore_done)
  );

  assign pc_o        = pc_q;
  assign pc_we_o     = pc_we_q;
  assign halt_o      = halt_q;
  assign resume_o    = resume_q;
  assign shift_o     = shift_q;
  assign busy_o      = busy_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Bench for ft_recovery_ctrl: table of recovery events plus hand-written
// sequences for persistent error, clean-window boundary and mid-restore reset.
// Expectations follow FT_SHIFT_EN the same way the design does.
module tb_ft_recovery_ctrl;
  import ft_pkg::*;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int DEPTH    = 32;
  localparam int HALT_CYC = 2;
  localparam int BASE_LAT = HALT_CYC + (DEPTH + 1) + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic              err_i = 1'b0;
  logic [DW-1:0]     spc_i = '0;
  logic [DW-1:0]     ck_rdata = '0;
  logic [AW-1:0]     ck_raddr_o;
  logic              rf_we_o;
  logic [AW-1:0]     rf_waddr_o;
  logic [DW-1:0]     rf_wdata_o;
  logic [DW-1:0]     pc_o;
  logic              pc_we_o;
  logic              halt_o;
  logic              resume_o;
  logic              shift_o;
  logic              busy_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  ft_recovery_ctrl #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .HALT_CYCLES  (HALT_CYC),
    .MAX_RETRY    (3),
    .CLEAN_CYCLES (64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .err_i       (err_i),
    .spc_i       (spc_i),
    .ck_rdata_i  (ck_rdata),
    .ck_raddr_o  (ck_raddr_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .pc_o        (pc_o),
    .pc_we_o     (pc_we_o),
    .halt_o      (halt_o),
    .resume_o    (resume_o),
    .shift_o     (shift_o),
    .busy_o      (busy_o),
    .retry_cnt_o (retry_cnt_o)
  );

  // Checkpoint file model: one-cycle synchronous read.
  logic [DW-1:0] ck_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ck_mem[i] = '0;
  always @(posedge clk) ck_rdata <= ck_mem[ck_raddr_o];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    pc_exp_q[$];
  int shift_cnt  = 0;
  int resume_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {44'd0, ck_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_o, pc_we_o,
            halt_o, resume_o, shift_o, busy_o, retry_cnt_o};
  endfunction

  // Output monitor: pops expected restore writes and PC loads.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rf_we_o) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("restore_write", {rf_waddr_o, rf_wdata_o}, exp_q.pop_front());
      end
      if (pc_we_o) begin
        check("pc_expected", pc_exp_q.size() != 0, 1);
        if (pc_exp_q.size() != 0) check("pc_load", pc_o, pc_exp_q.pop_front());
      end
      if (shift_o)  shift_cnt++;
      if (resume_o) resume_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < DEPTH; i++) ck_mem[i] = ramp ? DW'(i * 10) : DW'($urandom);
  endtask

  task automatic push_expect(input logic [DW-1:0] spc);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), ck_mem[i]});
    pc_exp_q.push_back(spc);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    err_i = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    pc_exp_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for resume_o; flags any halt_o drop before it.
  task automatic wait_resume(output int n, output bit seen, output bit halt_drop);
    n = 0; seen = 1'b0; halt_drop = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (resume_o) seen = 1'b1;
      else if (!halt_o) halt_drop = 1'b1;
    end
  endtask

  // One single-cycle error, full recovery, checked against expectations.
  task automatic run_recovery(input logic [DW-1:0] spc, input bit ramp, input int exp_lat,
                              input int exp_shift, input logic [RETRY_W-1:0] exp_retry);
    int n; bit seen; bit drop; int shift0;
    fill_mem(ramp);
    push_expect(spc);
    shift0 = shift_cnt;
    err_i = 1'b1;
    spc_i = spc;
    @(negedge clk);
    err_i = 1'b0;
    spc_i = DW'($urandom);
    check("halt_rise", {halt_o, busy_o}, 2'b11);
    wait_resume(n, seen, drop);
    check("resume_seen", seen, 1);
    check("resume_latency", n + 1, exp_lat);
    check("halt_held", drop, 0);
    check("retry_after", retry_cnt_o, exp_retry);
    check("writes_done", exp_q.size(), 0);
    check("pc_done", pc_exp_q.size(), 0);
    check("shift_pulses", shift_cnt - shift0, exp_shift);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                 gap;
    logic [DW-1:0]      spc;
    logic [RETRY_W-1:0] pre_retry;
    int                 exp_lat;
    int                 exp_shift;
    logic [RETRY_W-1:0] exp_retry;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n; bit seen; bit drop; int rbase;

    vecs[0] = '{gap: 5,  spc: 32'h98,       pre_retry: 0, exp_lat: BASE_LAT, exp_shift: 0, exp_retry: 1};
    vecs[1] = '{gap: 10, spc: 32'h1000,     pre_retry: 1, exp_lat: BASE_LAT, exp_shift: 0, exp_retry: 2};
    vecs[2] = '{gap: 3,  spc: 32'hdeadbeef, pre_retry: 2, exp_lat: BASE_LAT, exp_shift: 0, exp_retry: 3};
`ifdef FT_SHIFT_EN
    vecs[3] = '{gap: 20, spc: 32'h44,       pre_retry: 3, exp_lat: BASE_LAT + 1, exp_shift: 1, exp_retry: 1};
`else
    vecs[3] = '{gap: 20, spc: 32'h44,       pre_retry: 3, exp_lat: BASE_LAT, exp_shift: 0, exp_retry: 4};
`endif
    vecs[4] = '{gap: 70, spc: 32'h55,       pre_retry: 0, exp_lat: BASE_LAT, exp_shift: 0, exp_retry: 1};

    // Reset held: everything low.
    repeat (4) @(negedge clk);
    check("reset_outputs", all_outs(), 128'd0);
    rst_i = 1'b0;
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (all_outs() != 128'd0) bad = 1'b1;
      end
      check("idle_100_cycles_quiet", bad, 0);
    end

    // Table: recoveries spaced by idle gaps.
    for (int v = 0; v < 5; v++) begin
      repeat (vecs[v].gap) @(negedge clk);
      check("pre_idle", {busy_o, halt_o}, 2'b00);
      check("pre_retry", retry_cnt_o, vecs[v].pre_retry);
      run_recovery(vecs[v].spc, v == 0, vecs[v].exp_lat, vecs[v].exp_shift, vecs[v].exp_retry);
    end

    // Clean-window boundary: retry count survives 64 idle cycles, clears on the 65th.
    do_reset();
    run_recovery(32'h0abc, 1'b0, BASE_LAT, 0, 1);
    repeat (64) @(negedge clk);
    check("clean_edge_before", retry_cnt_o, 1);
    @(negedge clk);
    check("clean_edge_after", retry_cnt_o, 0);

    // err_i held through a whole recovery: no restart, re-accept right after resume.
    do_reset();
    fill_mem(1'b0);
    push_expect(32'h1111);
    push_expect(32'h1111);
    err_i = 1'b1;
    spc_i = 32'h1111;
    @(negedge clk);
    check("persist_halt_rise", halt_o, 1);
    wait_resume(n, seen, drop);
    check("persist_first_latency", n + 1, BASE_LAT);
    check("persist_no_restart", {drop, 26'(exp_q.size())}, {1'b0, 26'(DEPTH)});
    @(negedge clk);
    check("persist_idle_gap", {halt_o, busy_o}, 2'b00);
    @(negedge clk);
    check("persist_reaccept", {halt_o, busy_o}, 2'b11);
    err_i = 1'b0;
    wait_resume(n, seen, drop);
    check("persist_second_latency", n + 1, BASE_LAT);
    check("persist_retry", retry_cnt_o, 2);
    check("persist_writes_done", exp_q.size(), 0);

    // Reset while restoring address 15: immediate quiet, no replay, no resume.
    do_reset();
    fill_mem(1'b0);
    push_expect(32'h77);
    err_i = 1'b1;
    spc_i = 32'h77;
    @(negedge clk);
    err_i = 1'b0;
    n = 0;
    while (!(busy_o && ck_raddr_o == AW'(15)) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("reached_addr15", ck_raddr_o, 15);
    check("writing_at_addr15", rf_we_o, 1);
    rst_i = 1'b1;
    #1;
    check("midreset_outputs", all_outs(), 128'd0);
    exp_q.delete();
    pc_exp_q.delete();
    rbase = resume_cnt;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (busy_o || halt_o || rf_we_o || pc_we_o) bad = 1'b1;
      end
      check("after_reset_idle", bad, 0);
    end
    check("after_reset_no_resume", resume_cnt - rbase, 0);
    check("after_reset_retry", retry_cnt_o, 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time budget, errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
